// File: rtl/mem_line_pkg.sv
// Shared types and widths for the 128-bit cache line memory interface.
package mem_line_pkg;

  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_resp_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_t;

endpackage

// File: rtl/mem_line_store.sv
// Single-port line store: synchronous write, registered read, contents never reset.
module mem_line_store
  import mem_line_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**IDX_W];
  logic [LINE_W-1:0] rdata_reg;

  // Read-first: a write cycle returns the old line, which the top ignores.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line memory responder: captures a held request in IDLE, answers with a one-cycle mem_ready.
// Define MEM_LINE_RESPONDER_PROTO_CHECK_EN to build the sticky proto_err request-protocol checker.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  proto_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_resp_state_t   state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  mem_op_t           op_reg, op_next;

  logic              req;
  mem_op_t           req_op;
  logic              store_we;
  logic [IDX_W-1:0]  store_addr;
  logic [LINE_W-1:0] store_rdata;

  assign req    = mem_read || mem_write;
  assign req_op = mem_write ? OP_WR : OP_RD;

  // Upper line-address bits alias onto the store.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_addr[MEM_ADDR_W-1:IDX_W]};

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      op_reg    <= OP_RD;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          idx_next   = mem_addr[IDX_W-1:0];
          wdata_next = mem_wdata;
          op_next    = req_op;
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The store read port follows the live address in IDLE so that a LATENCY=1
  // read has its line registered on the same edge that enters DONE.
  always_comb begin
    store_addr = idx_reg;
    store_we   = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    if (state_reg == IDLE) begin
      store_addr = mem_addr[IDX_W-1:0];
    end
    if (state_reg == DONE) begin
      mem_ready = 1'b1;
      store_we  = (op_reg == OP_WR);
      mem_rdata = (op_reg == OP_WR) ? wdata_reg : store_rdata;
    end
  end

  mem_line_store #(
    .IDX_W(IDX_W)
  ) u_store (
    .clk  (clk),
    .we   (store_we),
    .addr (store_addr),
    .wdata(wdata_reg),
    .rdata(store_rdata)
  );

`ifdef MEM_LINE_RESPONDER_PROTO_CHECK_EN
  logic [MEM_ADDR_W-1:0] addr_reg;
  logic                  proto_err_reg;
  logic                  viol;

  always_comb begin
    viol = 1'b0;
    case (state_reg)
      IDLE:    viol = mem_read && mem_write;
      WAIT:    viol = !req || (mem_addr != addr_reg) || (req_op != op_reg);
      default: viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      addr_reg      <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && req) begin
        addr_reg <= mem_addr;
      end
      if (viol) begin
        proto_err_reg <= 1'b1;
        if (!proto_err_reg) begin
          $error("mem_line_responder: request protocol violation in state %s", state_reg.name());
        end
      end
    end
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed table, reset abandon, randomized traffic, LATENCY=1 pacing.
module tb_mem_line_responder;

  localparam int LAT  = 4;
  localparam int IDXW = 8;

`ifdef MEM_LINE_RESPONDER_PROTO_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset_n;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, proto_err;

  logic         rd1, wr1;
  logic [27:0]  addr1;
  logic [127:0] wd1, rdata1;
  logic         ready1, perr1;

  mem_line_responder #(.LATENCY(LAT), .IDX_W(IDXW)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .proto_err(proto_err)
  );

  mem_line_responder #(.LATENCY(1), .IDX_W(IDXW)) dut1 (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(rdata1), .mem_ready(ready1), .proto_err(perr1)
  );

  typedef struct {
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [127:0] model [int];
  bit exp_perr = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cache-side model: hold the request until mem_ready, then drop it.
  task automatic do_txn(input bit rd, input bit wr, input logic [27:0] addr, input logic [127:0] wd,
                        input bit perturb, output logic [127:0] rdata, output int lat);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat   = i;
        rdata = mem_rdata;
        break;
      end
      if (i == 1 && perturb) begin
        mem_addr  = addr ^ 28'h0000001;
        mem_wdata = ~wd;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("ready_single_cycle", mem_ready, 1'b0);
  endtask

  task automatic run(input bit rd, input bit wr, input logic [27:0] addr, input logic [127:0] wd,
                     input bit perturb, input bit has_exp, input logic [127:0] exp, input string tag);
    logic [127:0] rdat;
    int lat;
    int idx;
    idx = int'(addr) % (1 << IDXW);
    do_txn(rd, wr, addr, wd, perturb, rdat, lat);
    chk({tag, " latency"}, 128'(lat), 128'(LAT));
    if (has_exp) chk({tag, " rdata"}, rdat, exp);
    else if (wr) chk({tag, " rdata"}, rdat, wd);
    else if (model.exists(idx)) chk({tag, " rdata"}, rdat, model[idx]);
    if (wr) model[idx] = wd;
    if (CHECK_EN && ((rd && wr) || perturb)) exp_perr = 1'b1;
    chk({tag, " proto_err"}, proto_err, exp_perr);
  endtask

  localparam logic [127:0] DA = 128'hA5A5_0000_1111_2222_3333_4444_5555_0005;
  localparam logic [127:0] DX = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] DB = 128'hBBBB_0000_2020_2020_0000_BBBB_1234_0020;
  localparam logic [127:0] DC = 128'hCCCC_3030_3030_CCCC_DEAD_BEEF_0000_0030;
  localparam logic [127:0] DD = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
  localparam logic [127:0] DE = 128'hEEEE_4040_0000_1111_EEEE_4040_2222_3333;
  localparam logic [127:0] DW = 128'h7777_0001_0002_0003_0004_0005_0006_0007;

  initial begin
    vec_t vec[9];
    bit seen;
    bit rr, ww, pp;
    logic [27:0] ra;
    logic [127:0] rw;

    vec[0] = '{1'b0, 1'b1, 28'h0000005, DA, DA};
    vec[1] = '{1'b1, 1'b0, 28'h0000005, '0, DA};
    vec[2] = '{1'b0, 1'b1, 28'h0000010, DX, DX};
    vec[3] = '{1'b1, 1'b0, 28'h0000010, '0, DX};
    vec[4] = '{1'b1, 1'b0, 28'h0000105, '0, DA};
    vec[5] = '{1'b0, 1'b1, 28'h0000020, DB, DB};
    vec[6] = '{1'b1, 1'b1, 28'h0000030, DC, DC};
    vec[7] = '{1'b1, 1'b0, 28'h0000030, '0, DC};
    vec[8] = '{1'b1, 1'b0, 28'hABCD020, '0, DB};

    proc_reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", mem_ready, 1'b0);
    chk("reset rdata", mem_rdata, '0);
    chk("reset proto_err", proto_err, 1'b0);
    chk("reset ready1", ready1, 1'b0);
    proc_reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata, 1'b0, 1'b1, vec[i].exp,
          $sformatf("vec%0d", i));
    end

    // Inputs changing during WAIT must not affect the captured write.
    run(1'b0, 1'b1, 28'h0000040, DE, 1'b1, 1'b1, DE, "perturb_wr");
    run(1'b1, 1'b0, 28'h0000040, '0, 1'b0, 1'b1, DE, "perturb_rd");

    // Reset two cycles into a write abandons it.
    seen = 1'b0;
    mem_write = 1'b1; mem_addr = 28'h0000020; mem_wdata = DD;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    proc_reset_n = 1'b0;
    #1;
    chk("midreset ready", mem_ready, 1'b0);
    chk("midreset rdata", mem_rdata, '0);
    chk("midreset proto_err", proto_err, 1'b0);
    @(posedge clk); #1;
    if (mem_ready) seen = 1'b1;
    mem_write = 1'b0;
    proc_reset_n = 1'b1;
    exp_perr = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    chk("abandon no ready", seen, 1'b0);
    run(1'b1, 1'b0, 28'h0000020, '0, 1'b0, 1'b1, DB, "abandon_old");

    // Randomized traffic over a small index pool so reads hit prior writes.
    for (int n = 0; n < 60; n++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      if (!rr && !ww) rr = 1'b1;
      pp = ($urandom_range(0, 5) == 0);
      ra = (28'($urandom) & 28'hFFFFF00) | 28'($urandom_range(0, 15));
      rw = {$urandom, $urandom, $urandom, $urandom};
      run(rr, ww, ra, rw, pp, 1'b0, '0, $sformatf("rnd%0d", n));
    end

    // LATENCY=1 with the request held continuously: ready every other cycle.
    wr1 = 1'b1; addr1 = 28'h0000005; wd1 = DW;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lat1 ready edge%0d", i), ready1, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (ready1) chk($sformatf("lat1 wr rdata edge%0d", i), rdata1, DW);
    end
    wr1 = 1'b0; rd1 = 1'b1;
    @(posedge clk); #1;
    chk("lat1 raw ready", ready1, 1'b1);
    chk("lat1 raw rdata", rdata1, DW);
    rd1 = 1'b0;
    @(posedge clk); #1;
    chk("lat1 ready drop", ready1, 1'b0);
    chk("lat1 proto_err", perr1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
